// File: rtl/pscan_pkg.sv
// rtl/pscan_pkg.sv - shared types, constants and window-match helper for the pattern scanner
// Purpose: FSM state encoding, pattern width, result offsets, and match4()
//          which counts how many of the four in-byte 5-bit windows equal the pattern.
// Ports:   none (package)
package pscan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDPAT,
    S_SCAN,
    S_WR_B,
    S_WR_O,
    S_WR_S,
    S_DONE
  } state_t;

  localparam int PAT_W   = 5;
  localparam int RES_CTB = 0;
  localparam int RES_CTO = 1;
  localparam int RES_CTS = 2;

  // Windows cur[4:0], cur[5:1], cur[6:2], cur[7:3]; at most 4 hits, so 3 bits.
  function automatic logic [2:0] match4(input logic [7:0] data, input logic [PAT_W-1:0] pat);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (data[i +: PAT_W] == pat) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/window_match.sv
// rtl/window_match.sv - combinational in-byte and byte-crossing 5-bit window matcher
// Purpose: counts pattern hits inside the current byte and across the prev/cur boundary.
// Ports:   prev[7:0]       previous message byte
//          cur[7:0]        current message byte
//          pat[4:0]        search pattern
//          first           1 on message byte 0 (no previous byte exists)
//          inbyte_cnt[2:0] hits among the four windows wholly inside cur
//          any_in          at least one in-byte hit
//          cross_cnt[2:0]  hits among the four windows straddling prev/cur, 0 when first
module window_match
  import pscan_pkg::*;
(
  input  logic [7:0]       prev,
  input  logic [7:0]       cur,
  input  logic [PAT_W-1:0] pat,
  input  logic             first,
  output logic [2:0]       inbyte_cnt,
  output logic             any_in,
  output logic [2:0]       cross_cnt
);

  logic [15:0] w;

  assign w          = {prev, cur};
  assign inbyte_cnt = match4(cur, pat);
  assign any_in     = (inbyte_cnt != 3'd0);

  // Straddling windows are w[8:4] .. w[11:7]: each takes 1..4 bits from prev.
  always_comb begin
    cross_cnt = 3'd0;
    if (!first) begin
      for (int i = 4; i < 8; i++) begin
        if (w[i +: PAT_W] == pat) cross_cnt = cross_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/pattern_scan_unit.sv
// rtl/pattern_scan_unit.sv - data-memory bus master that counts 5-bit pattern matches in a message
// Purpose: on start, loads the pattern, scans STR_LEN message bytes one per cycle and
//          writes three match counts (in-byte total, bytes with a hit, full-string total).
// Ports:   clk             clock
//          reset           synchronous active-high reset
//          start           run request, honoured only in IDLE or DONE
//          done            level acknowledge, high in DONE
//          mem_addr[AW-1:0] data-memory address
//          mem_wen         data-memory write enable
//          mem_wdata[7:0]  data-memory write data
//          mem_rdata[7:0]  combinational read data for mem_addr
module pattern_scan_unit
  import pscan_pkg::*;
#(
  parameter int AW       = 8,
  parameter int STR_BASE = 0,
  parameter int STR_LEN  = 32,
  parameter int PAT_ADDR = 32,
  parameter int RES_ADDR = 33
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  state_t           state, state_nx;
  logic [PAT_W-1:0] pat;
  logic [7:0]       prev, ctb, cto, cts;
  logic [AW-1:0]    idx;
  logic [2:0]       inbyte_cnt, cross_cnt;
  logic             any_in;
  logic             last_byte;

  window_match u_window_match (
    .prev       (prev),
    .cur        (mem_rdata),
    .pat        (pat),
    .first      (idx == '0),
    .inbyte_cnt (inbyte_cnt),
    .any_in     (any_in),
    .cross_cnt  (cross_cnt)
  );

  assign last_byte = (idx == AW'(STR_LEN - 1));

  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = 8'd0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_LDPAT;
      end
      S_LDPAT: begin
        mem_addr = AW'(PAT_ADDR);
        state_nx = S_SCAN;
      end
      S_SCAN: begin
        mem_addr = AW'(STR_BASE) + idx;
        if (last_byte) state_nx = S_WR_B;
      end
      S_WR_B: begin
        mem_addr  = AW'(RES_ADDR + RES_CTB);
        mem_wen   = 1'b1;
        mem_wdata = ctb;
        state_nx  = S_WR_O;
      end
      S_WR_O: begin
        mem_addr  = AW'(RES_ADDR + RES_CTO);
        mem_wen   = 1'b1;
        mem_wdata = cto;
        state_nx  = S_WR_S;
      end
      S_WR_S: begin
        mem_addr  = AW'(RES_ADDR + RES_CTS);
        mem_wen   = 1'b1;
        mem_wdata = cts;
        state_nx  = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nx = S_LDPAT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pat   <= '0;
      prev  <= 8'd0;
      idx   <= '0;
      ctb   <= 8'd0;
      cto   <= 8'd0;
      cts   <= 8'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_LDPAT: begin
          pat  <= mem_rdata[7:3];
          prev <= 8'd0;
          idx  <= '0;
          ctb  <= 8'd0;
          cto  <= 8'd0;
          cts  <= 8'd0;
        end
        S_SCAN: begin
          ctb  <= ctb + {5'd0, inbyte_cnt};
          cto  <= cto + {7'd0, any_in};
          cts  <= cts + {5'd0, inbyte_cnt} + {5'd0, cross_cnt};
          prev <= mem_rdata;
          idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_unit.sv
// tb/tb_pattern_scan_unit.sv - self-checking scoreboard bench for pattern_scan_unit
module tb_pattern_scan_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_wen;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  always #5 clk = ~clk;

  pattern_scan_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] mem [0:255];
  logic [7:0] img [0:255];
  logic       load;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t sb [$];
  wr_t exp_wr;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        exp_wr = sb.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, exp_wr.addr});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, exp_wr.data});
      end
    end
  end

  // Golden counts from the image: message as a 256-bit string, byte 0 bit 7 first.
  task automatic golden(output logic [7:0] b, output logic [7:0] o, output logic [7:0] s);
    logic [4:0]   p;
    logic [255:0] str;
    logic         any;
    p = img[32][7:3];
    for (int i = 0; i < 32; i++) str[255 - 8*i -: 8] = img[i];
    b = 8'd0;
    o = 8'd0;
    s = 8'd0;
    for (int i = 0; i < 32; i++) begin
      any = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (str[255 - (8*i + j) -: 5] == p) begin
          b   = b + 8'd1;
          any = 1'b1;
        end
      end
      if (any) o = o + 8'd1;
    end
    for (int k = 0; k < 252; k++) begin
      if (str[255 - k -: 5] == p) s = s + 8'd1;
    end
  endtask

  task automatic load_img();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run(input int busy_at, input bit hold);
    logic [7:0] b, o, s;
    int c;
    golden(b, o, s);
    sb.push_back(wr_t'{8'd33, b});
    sb.push_back(wr_t'{8'd34, o});
    sb.push_back(wr_t'{8'd35, s});
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    check("done_drop", {31'd0, done}, 32'd0);
    c = 0;
    while (c < 60) begin
      @(posedge clk);
      #1;
      c++;
      if (!hold && busy_at != 0) start = (c == busy_at - 1);
      if (done) break;
    end
    check("latency", c, 32'd36);
    check("sb_drained", sb.size(), 32'd0);
    sb.delete();
    check("mem_ctb", {24'd0, mem[33]}, {24'd0, b});
    check("mem_cto", {24'd0, mem[34]}, {24'd0, o});
    check("mem_cts", {24'd0, mem[35]}, {24'd0, s});
  endtask

  initial begin
    logic wen_seen;
    reset = 1'b1;
    start = 1'b0;
    load  = 1'b0;
    for (int i = 0; i < 256; i++) img[i] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);

    // reset and start together: reset wins, unit stays in IDLE
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_start_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_start_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    start = 1'b0;

    // all zeros
    load_img();
    run(0, 0);
    check("zeros_ctb", {24'd0, mem[33]}, 32'd128);
    check("zeros_cto", {24'd0, mem[34]}, 32'd32);
    check("zeros_cts", {24'd0, mem[35]}, 32'd252);

    // single in-byte match
    img[0]  = 8'h15;
    img[32] = 8'hA8;
    load_img();
    run(0, 0);
    check("single_ctb", {24'd0, mem[33]}, 32'd1);
    check("single_cto", {24'd0, mem[34]}, 32'd1);
    check("single_cts", {24'd0, mem[35]}, 32'd1);

    // crossing-only match
    img[0]  = 8'h0F;
    img[1]  = 8'h80;
    img[32] = 8'hF8;
    load_img();
    run(0, 0);
    check("cross_ctb", {24'd0, mem[33]}, 32'd0);
    check("cross_cto", {24'd0, mem[34]}, 32'd0);
    check("cross_cts", {24'd0, mem[35]}, 32'd1);

    // busy pulse ignored, then back-to-back with start held in DONE
    for (int i = 0; i < 33; i++) img[i] = 8'($urandom);
    load_img();
    run(10, 0);
    run(0, 1);
    run(0, 0);

    // reset mid-scan
    for (int i = 0; i < 33; i++) img[i] = 8'($urandom);
    img[33] = 8'hA5;
    img[34] = 8'h5A;
    img[35] = 8'h3C;
    load_img();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_wen", {31'd0, mem_wen}, 32'd0);
    check("midrst_addr", {24'd0, mem_addr}, 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    wen_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      wen_seen = wen_seen | mem_wen;
    end
    check("midrst_no_write", {31'd0, wen_seen}, 32'd0);
    check("midrst_done_low", {31'd0, done}, 32'd0);
    check("midrst_keep33", {24'd0, mem[33]}, 32'hA5);
    check("midrst_keep34", {24'd0, mem[34]}, 32'h5A);
    check("midrst_keep35", {24'd0, mem[35]}, 32'h3C);
    run(0, 0);

    // random regression
    for (int r = 0; r < 200; r++) begin
      for (int i = 0; i < 33; i++) img[i] = 8'($urandom);
      load_img();
      run(0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
